// File: rtl/core_dmem_if_if.sv
// Data-memory bus interface between core_dmem_if and the memory system.
//   master modport: core side (drives request fields, receives ack/read data)
//   slave modport : memory side (receives request fields, drives ack/read data)
//   M_REQ   request, held high for the whole access
//   M_WE    write enable (1 = store)
//   M_ADDR  word-aligned byte address
//   M_WSTRB byte-lane strobe
//   M_WDATA lane-shifted write data
//   M_ACK   completion; M_RDATA valid in the same cycle
//   M_RDATA read data
interface core_dmem_if_if;
    logic        M_REQ;
    logic        M_WE;
    logic [31:0] M_ADDR;
    logic [3:0]  M_WSTRB;
    logic [31:0] M_WDATA;
    logic        M_ACK;
    logic [31:0] M_RDATA;

    modport master (
        output M_REQ,
        output M_WE,
        output M_ADDR,
        output M_WSTRB,
        output M_WDATA,
        input  M_ACK,
        input  M_RDATA
    );

    modport slave (
        input  M_REQ,
        input  M_WE,
        input  M_ADDR,
        input  M_WSTRB,
        input  M_WDATA,
        output M_ACK,
        output M_RDATA
    );
endinterface

// File: rtl/core_dmem_if.sv
// Data-memory access unit between the mem-control pipeline stage and the memory bus.
// Accepts one load/store in IDLE, runs it on the bus in BUSY until M_ACK, then spends one
// DONE cycle presenting the aligned/extended load result (LOAD_VALID) before returning to IDLE.
//
// Ports:
//   CLK, NRST         clock (rising edge), asynchronous active-low reset
//   ISLOAD, ISSTORE   access request (both high = load), sampled only in IDLE
//   DMEM_ADDR         byte address; STRB byte-lane strobe (0 = no access)
//   ISLOADBS/HWS      signed byte / signed halfword load
//   STORE_DATA        right-aligned store data
//   bus               core_dmem_if_if.master memory bus
//   STALL             pipeline hold (combinational)
//   LOAD_DATA         load result, held until the next load completes
//   LOAD_VALID        one-cycle pulse in DONE for loads
//   ERR               one-cycle misalignment fault pulse
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of
// issuing them on the bus. Without it ERR is always 0.
module core_dmem_if (
    input  logic         CLK,
    input  logic         NRST,
    input  logic         ISLOAD,
    input  logic         ISSTORE,
    input  logic [31:0]  DMEM_ADDR,
    input  logic [3:0]   STRB,
    input  logic         ISLOADBS,
    input  logic         ISLOADHWS,
    input  logic [31:0]  STORE_DATA,
    core_dmem_if_if.master bus,
    output logic         STALL,
    output logic [31:0]  LOAD_DATA,
    output logic         LOAD_VALID,
    output logic         ERR
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
    typedef enum logic [1:0] {WByte, WHalf, WWord} width_e;

    state_e      state_q;
    width_e      width_q;
    width_e      req_width;
    logic        sign_q;
    logic        req_sign;
    logic        is_store_q;
    logic [1:0]  addr_lo_q;
    logic        accept;
    logic        misalign;

    logic        m_req_q;
    logic        m_we_q;
    logic [31:0] m_addr_q;
    logic [3:0]  m_wstrb_q;
    logic [31:0] m_wdata_q;
    logic [31:0] load_data_q;
    logic        load_valid_q;
    logic        err_q;

    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    assign accept = (state_q == StIdle) && (ISLOAD || ISSTORE) && (STRB != 4'b0000);
    assign STALL  = accept || (state_q == StBusy);

    // Access width is implied by how many lanes the strobe enables.
    always_comb begin
        req_width = WWord;
        case (STRB)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: req_width = WByte;
            4'b0011, 4'b1100:                   req_width = WHalf;
            default:                            req_width = WWord;
        endcase
    end

    always_comb begin
        req_sign = 1'b0;
        case (req_width)
            WByte:   req_sign = ISLOADBS;
            WHalf:   req_sign = ISLOADHWS;
            default: req_sign = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_width == WHalf) && DMEM_ADDR[0]) ||
                      ((req_width == WWord) && (DMEM_ADDR[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Bring the addressed lane down to bit 0, then extend by the registered width.
    assign rdata_shifted = bus.M_RDATA >> {addr_lo_q, 3'b000};

    always_comb begin
        load_ext = rdata_shifted;
        case (width_q)
            WByte:   load_ext = {{24{sign_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            WHalf:   load_ext = {{16{sign_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q      <= StIdle;
            width_q      <= WWord;
            sign_q       <= 1'b0;
            is_store_q   <= 1'b0;
            addr_lo_q    <= 2'b00;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= 32'h0;
            m_wstrb_q    <= 4'h0;
            m_wdata_q    <= 32'h0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        width_q    <= req_width;
                        sign_q     <= req_sign;
                        is_store_q <= !ISLOAD;   // load wins when both are high
                        addr_lo_q  <= DMEM_ADDR[1:0];
                        m_we_q     <= !ISLOAD;
                        m_addr_q   <= {DMEM_ADDR[31:2], 2'b00};
                        m_wstrb_q  <= STRB;
                        m_wdata_q  <= STORE_DATA << {DMEM_ADDR[1:0], 3'b000};
                        if (misalign) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            m_req_q <= 1'b1;
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (bus.M_ACK) begin
                        m_req_q <= 1'b0;
                        state_q <= StDone;
                        if (!is_store_q) begin
                            load_data_q  <= load_ext;
                            load_valid_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    m_req_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.M_REQ   = m_req_q;
    assign bus.M_WE    = m_we_q;
    assign bus.M_ADDR  = m_addr_q;
    assign bus.M_WSTRB = m_wstrb_q;
    assign bus.M_WDATA = m_wdata_q;
    assign LOAD_DATA   = load_data_q;
    assign LOAD_VALID  = load_valid_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_core_dmem_if.sv
// Scoreboard bench for core_dmem_if: stimulus pushes expected bus requests and expected
// completion events; a negedge monitor pops and compares whenever the DUT presents them.
module tb_core_dmem_if;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic        ISLOAD = 1'b0;
    logic        ISSTORE = 1'b0;
    logic [31:0] DMEM_ADDR = 32'h0;
    logic [3:0]  STRB = 4'h0;
    logic        ISLOADBS = 1'b0;
    logic        ISLOADHWS = 1'b0;
    logic [31:0] STORE_DATA = 32'h0;
    logic        STALL;
    logic [31:0] LOAD_DATA;
    logic        LOAD_VALID;
    logic        ERR;

    core_dmem_if_if bus ();

    core_dmem_if dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .ISLOAD     (ISLOAD),
        .ISSTORE    (ISSTORE),
        .DMEM_ADDR  (DMEM_ADDR),
        .STRB       (STRB),
        .ISLOADBS   (ISLOADBS),
        .ISLOADHWS  (ISLOADHWS),
        .STORE_DATA (STORE_DATA),
        .bus        (bus.master),
        .STALL      (STALL),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_VALID (LOAD_VALID),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [1:0]  kind;   // {LOAD_VALID, ERR}
        logic [31:0] data;
        int          at;
    } evt_exp_t;

    bus_exp_t bus_q[$];
    evt_exp_t evt_q[$];
    bus_exp_t cur_bus;
    int n_cmp = 0;
    int n_bad = 0;
    logic req_prev = 1'b0;
    logic [31:0] last_load = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: bus requests on M_REQ rise, completion events on LOAD_VALID/ERR.
    always @(negedge CLK) begin
        if (bus.M_REQ && !req_prev) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_m_req", 32'(bus.M_REQ), 32'd0);
            end else begin
                cur_bus = bus_q.pop_front();
                chk("m_addr", bus.M_ADDR, cur_bus.addr);
                chk("m_we", 32'(bus.M_WE), 32'(cur_bus.we));
                chk("m_wstrb", 32'(bus.M_WSTRB), 32'(cur_bus.wstrb));
                chk("m_wdata", bus.M_WDATA, cur_bus.wdata);
            end
        end
        if (bus.M_REQ && bus.M_ACK) begin
            chk("m_addr_stable", bus.M_ADDR, cur_bus.addr);
            chk("m_wdata_stable", bus.M_WDATA, cur_bus.wdata);
        end
        req_prev = bus.M_REQ;
        if (LOAD_VALID || ERR) begin
            if (evt_q.size() == 0) begin
                chk("unexpected_event", {30'd0, LOAD_VALID, ERR}, 32'd0);
            end else begin
                evt_exp_t e;
                e = evt_q.pop_front();
                chk("event_kind", {30'd0, LOAD_VALID, ERR}, {30'd0, e.kind});
                chk("load_data", LOAD_DATA, e.data);
                chk("event_cycle", cyc, e.at);
            end
        end
    end

    // Called at #1 after a rising edge with the DUT idle.
    task automatic access(input bit ld, input bit st, input logic [31:0] addr,
                          input logic [3:0] strb, input bit bs, input bit hws,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int delay,
                          input bit on_bus, input logic [31:0] exp_addr, input bit exp_we,
                          input logic [31:0] exp_wdata, input logic [1:0] kind,
                          input logic [31:0] exp_data);
        int acc;
        evt_exp_t e;
        bus_exp_t b;
        ISLOAD = ld; ISSTORE = st; DMEM_ADDR = addr; STRB = strb;
        ISLOADBS = bs; ISLOADHWS = hws; STORE_DATA = sdata;
        #1 chk("stall_accept", 32'(STALL), 32'd1);
        if (on_bus) begin
            b.addr = exp_addr; b.we = exp_we; b.wstrb = strb; b.wdata = exp_wdata;
            bus_q.push_back(b);
        end
        @(posedge CLK); #1;
        acc = cyc;
        ISLOAD = 1'b0; ISSTORE = 1'b0; STRB = 4'h0; STORE_DATA = 32'h0;
        if (kind != 2'b00) begin
            e.kind = kind; e.data = exp_data; e.at = acc + 1 + (on_bus ? delay : 0);
            evt_q.push_back(e);
        end
        if (on_bus) begin
            chk("stall_busy", 32'(STALL), 32'd1);
            repeat (delay) begin @(posedge CLK); #1; end
            chk("m_req_busy", 32'(bus.M_REQ), 32'd1);
            bus.M_ACK = 1'b1; bus.M_RDATA = rdata;
            @(posedge CLK); #1;
            bus.M_ACK = 1'b0; bus.M_RDATA = 32'hDEAD_0000;
        end
        chk("stall_done", 32'(STALL), 32'd0);
        chk("m_req_done", 32'(bus.M_REQ), 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        bus.M_ACK = 1'b0;
        bus.M_RDATA = 32'h0;
        #1;
        chk("rst_m_req", 32'(bus.M_REQ), 32'd0);
        chk("rst_m_we", 32'(bus.M_WE), 32'd0);
        chk("rst_m_addr", bus.M_ADDR, 32'd0);
        chk("rst_m_wstrb", 32'(bus.M_WSTRB), 32'd0);
        chk("rst_m_wdata", bus.M_WDATA, 32'd0);
        chk("rst_load_data", LOAD_DATA, 32'd0);
        chk("rst_load_valid", 32'(LOAD_VALID), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        repeat (2) @(posedge CLK);
        #1 NRST = 1'b1;

        // LB 0x103, ack after 2 cycles
        access(1, 0, 32'h103, 4'h8, 1, 0, 32'h0, 32'h8011_2233, 2,
               1, 32'h100, 0, 32'h0, 2'b10, 32'hFFFF_FF80);
        // SB 0x201
        access(0, 1, 32'h201, 4'h2, 0, 0, 32'h0000_00AB, 32'h0, 1,
               1, 32'h200, 1, 32'h0000_AB00, 2'b00, 32'h0);
        chk("hold_after_sb", LOAD_DATA, 32'hFFFF_FF80);
        // LHU 0x002, ack in first BUSY cycle (minimum latency)
        access(1, 0, 32'h002, 4'hC, 0, 0, 32'h0, 32'hBEEF_1234, 0,
               1, 32'h000, 0, 32'h0, 2'b10, 32'h0000_BEEF);
        // LH 0x000 signed
        access(1, 0, 32'h000, 4'h3, 0, 1, 32'h0, 32'h1234_8001, 1,
               1, 32'h000, 0, 32'h0, 2'b10, 32'hFFFF_8001);
        // LBU 0x101
        access(1, 0, 32'h101, 4'h2, 0, 0, 32'h0, 32'h8011_2233, 3,
               1, 32'h100, 0, 32'h0, 2'b10, 32'h0000_0022);
        // SW 0x300, load data must hold
        access(0, 1, 32'h300, 4'hF, 0, 0, 32'hDEAD_BEEF, 32'h0, 0,
               1, 32'h300, 1, 32'hDEAD_BEEF, 2'b00, 32'h0);
        chk("hold_after_sw", LOAD_DATA, 32'h0000_0022);
        // ISLOAD and ISSTORE together -> load
        access(1, 1, 32'h008, 4'hF, 0, 0, 32'h1111_1111, 32'h55AA_00FF, 1,
               1, 32'h008, 0, 32'h1111_1111, 2'b10, 32'h55AA_00FF);
        last_load = 32'h55AA_00FF;

        // STRB=0 request plus stray ack in IDLE
        ISLOAD = 1'b1; STRB = 4'h0; DMEM_ADDR = 32'h44; bus.M_ACK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stray_stall", 32'(STALL), 32'd0);
            chk("stray_m_req", 32'(bus.M_REQ), 32'd0);
            @(posedge CLK); #1;
        end
        ISLOAD = 1'b0; bus.M_ACK = 1'b0;
        chk("stray_hold", LOAD_DATA, last_load);

        // Reset mid-BUSY
        begin
            bus_exp_t b;
            b.addr = 32'h10; b.we = 1'b0; b.wstrb = 4'hF; b.wdata = 32'h0;
            bus_q.push_back(b);
            ISLOAD = 1'b1; DMEM_ADDR = 32'h10; STRB = 4'hF;
            @(posedge CLK); #1;
            ISLOAD = 1'b0; STRB = 4'h0;
            @(posedge CLK); #1;
            chk("pre_rst_m_req", 32'(bus.M_REQ), 32'd1);
            NRST = 1'b0;
            #1 chk("rst_busy_m_req", 32'(bus.M_REQ), 32'd0);
            chk("rst_busy_stall", 32'(STALL), 32'd0);
            chk("rst_busy_m_addr", bus.M_ADDR, 32'd0);
            chk("rst_busy_load_data", LOAD_DATA, 32'd0);
            @(posedge CLK); #1;
            NRST = 1'b1;
        end
        access(1, 0, 32'h010, 4'hF, 0, 0, 32'h0, 32'h0BAD_F00D, 1,
               1, 32'h010, 0, 32'h0, 2'b10, 32'h0BAD_F00D);
        last_load = 32'h0BAD_F00D;

        // LW at misaligned 0x006
`ifdef MISALIGN_TRAP_EN
        access(1, 0, 32'h006, 4'hF, 0, 0, 32'h0, 32'h0, 0,
               0, 32'h0, 0, 32'h0, 2'b01, last_load);
`else
        access(1, 0, 32'h006, 4'hF, 0, 0, 32'h0, 32'hCAFE_F00D, 0,
               1, 32'h004, 0, 32'h0, 2'b10, 32'h0000_CAFE);
`endif

        repeat (3) @(posedge CLK);
        #1;
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("evt_q_drained", 32'(evt_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
